// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the data-memory controller.
package dmem_pkg;

  localparam int DEFAULT_DEPTH_WORDS = 256;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Misaligned for its size, illegal size, or beyond the attached memory.
  function automatic logic req_is_bad(input logic [1:0]  size,
                                      input logic [31:0] addr,
                                      input logic [31:0] limit);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr[0];
      SZ_WORD: bad = (addr[1:0] != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad | (addr >= limit);
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response channel between one requester and the memory controller.
interface dmem_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/dmem_lane_fmt.sv
// Sub-word lane handling: load extract/extend and store read-modify-write merge.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_unsigned,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Load path: pick the addressed lane and extend it.
  always_comb begin
    w_byte = 8'h00;
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = 8'h00;
    endcase
    if (i_addr_lo[1]) begin
      w_half = i_rdata[31:16];
    end else begin
      w_half = i_rdata[15:0];
    end
    o_load = 32'h0000_0000;
    case (i_size)
      SZ_BYTE: o_load = i_unsigned ? {24'h00_0000, w_byte} : {{24{w_byte[7]}}, w_byte};
      SZ_HALF: o_load = i_unsigned ? {16'h0000, w_half} : {{16{w_half[15]}}, w_half};
      SZ_WORD: o_load = i_rdata;
      default: o_load = 32'h0000_0000;
    endcase
  end

  // Store path: overwrite only the addressed lane of the word just read.
  always_comb begin
    o_merge = i_rdata;
    case (i_size)
      SZ_BYTE: begin
        case (i_addr_lo)
          2'd0:    o_merge[7:0]   = i_wdata[7:0];
          2'd1:    o_merge[15:8]  = i_wdata[7:0];
          2'd2:    o_merge[23:16] = i_wdata[7:0];
          2'd3:    o_merge[31:24] = i_wdata[7:0];
          default: o_merge = i_rdata;
        endcase
      end
      SZ_HALF: begin
        if (i_addr_lo[1]) begin
          o_merge[31:16] = i_wdata[15:0];
        end else begin
          o_merge[15:0] = i_wdata[15:0];
        end
      end
      SZ_WORD: o_merge = i_wdata;
      default: o_merge = i_rdata;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Two-port arbiter and read-modify-write FSM in front of a single-port
// synchronous-read word memory.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  dmem_if.slave       a,
  dmem_if.slave       b,
  output logic        mem_write_en,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH_WORDS * 4);

  state_e      r_state;
  logic        r_last_b;
  logic        r_owner_b;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_err;

  logic        w_grant_b;
  logic        w_any;
  logic        w_idle;
  logic        w_sel_we;
  logic [1:0]  w_sel_size;
  logic        w_sel_unsigned;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic        w_sel_bad;
  logic [31:0] w_fmt_rdata;
  logic [31:0] w_load;
  logic [31:0] w_merge;
  logic [31:0] w_rdata;
  logic        w_resp;

  // Arbitration: lone requester wins; on a tie the port not granted last wins.
  always_comb begin
    if (a.req_valid && b.req_valid) begin
      w_grant_b = ~r_last_b;
    end else if (b.req_valid) begin
      w_grant_b = 1'b1;
    end else begin
      w_grant_b = 1'b0;
    end
  end

  assign w_any  = a.req_valid | b.req_valid;
  assign w_idle = (r_state == ST_IDLE);

  assign a.req_ready = w_idle & a.req_valid & ~w_grant_b;
  assign b.req_ready = w_idle & b.req_valid &  w_grant_b;

  assign w_sel_we       = w_grant_b ? b.req_we       : a.req_we;
  assign w_sel_size     = w_grant_b ? b.req_size     : a.req_size;
  assign w_sel_unsigned = w_grant_b ? b.req_unsigned : a.req_unsigned;
  assign w_sel_addr     = w_grant_b ? b.req_addr     : a.req_addr;
  assign w_sel_wdata    = w_grant_b ? b.req_wdata    : a.req_wdata;
  assign w_sel_bad      = req_is_bad(w_sel_size, w_sel_addr, ADDR_LIMIT);

  // Transaction FSM; request fields and owner are captured at acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_last_b   <= 1'b1;
      r_owner_b  <= 1'b0;
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_addr     <= 32'h0000_0000;
      r_wdata    <= 32'h0000_0000;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_last_b   <= w_grant_b;
            r_owner_b  <= w_grant_b;
            r_we       <= w_sel_we;
            r_size     <= w_sel_size;
            r_unsigned <= w_sel_unsigned;
            r_addr     <= w_sel_addr;
            r_wdata    <= w_sel_wdata;
            r_err      <= w_sel_bad;
            if (w_sel_bad) begin
              r_state <= ST_RESP;
            end else if (w_sel_we && (w_sel_size == SZ_WORD)) begin
              r_state <= ST_WR;
            end else begin
              r_state <= ST_RD;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RD:   r_state <= r_we ? ST_WR : ST_RESP;
        ST_WR:   r_state <= ST_RESP;
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Memory read data is only meaningful in the cycle after a read phase.
  assign w_fmt_rdata = ((r_state == ST_WR) || (r_state == ST_RESP)) ? mem_data_out : 32'h0000_0000;

  dmem_lane_fmt u_lane_fmt (
    .i_size     (r_size),
    .i_addr_lo  (r_addr[1:0]),
    .i_unsigned (r_unsigned),
    .i_rdata    (w_fmt_rdata),
    .i_wdata    (r_wdata),
    .o_load     (w_load),
    .o_merge    (w_merge)
  );

  // Memory drive decoded from state so reset removes a write at once.
  always_comb begin
    mem_write_en = 1'b0;
    mem_address  = 32'h0000_0000;
    mem_data_in  = 32'h0000_0000;
    case (r_state)
      ST_RD: begin
        mem_address = {r_addr[31:2], 2'b00};
      end
      ST_WR: begin
        mem_write_en = 1'b1;
        mem_address  = {r_addr[31:2], 2'b00};
        mem_data_in  = (r_size == SZ_WORD) ? r_wdata : w_merge;
      end
      default: begin
        mem_write_en = 1'b0;
        mem_address  = 32'h0000_0000;
        mem_data_in  = 32'h0000_0000;
      end
    endcase
  end

  assign w_resp  = (r_state == ST_RESP);
  assign w_rdata = (r_err | r_we) ? 32'h0000_0000 : w_load;

  assign a.resp_valid = w_resp & ~r_owner_b;
  assign a.resp_rdata = (w_resp & ~r_owner_b) ? w_rdata : 32'h0000_0000;
  assign a.resp_err   = w_resp & ~r_owner_b & r_err;
  assign b.resp_valid = w_resp & r_owner_b;
  assign b.resp_rdata = (w_resp & r_owner_b) ? w_rdata : 32'h0000_0000;
  assign b.resp_err   = w_resp & r_owner_b & r_err;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with a 256x32 synchronous-read memory model.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  logic        clk;
  logic        rst;
  logic        mem_write_en;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic [31:0] mem [0:255];

  int vectors     = 0;
  int miscompares = 0;

  dmem_if a_if ();
  dmem_if b_if ();

  dmem_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .a            (a_if),
    .b            (b_if),
    .mem_write_en (mem_write_en),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write_en) mem[mem_address[9:2]] <= mem_data_in;
    mem_data_out <= mem[mem_address[9:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input bit pb, input logic v, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wd);
    if (pb) begin
      b_if.req_valid = v; b_if.req_we = we; b_if.req_size = sz;
      b_if.req_unsigned = uns; b_if.req_addr = addr; b_if.req_wdata = wd;
    end else begin
      a_if.req_valid = v; a_if.req_we = we; a_if.req_size = sz;
      a_if.req_unsigned = uns; a_if.req_addr = addr; a_if.req_wdata = wd;
    end
  endtask

  // Issue one request from a negedge in IDLE and check its response and timing.
  task automatic do_req(input string tag, input bit pb, input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input int exp_lat, input int exp_wr);
    bit got = 1'b0;
    bit other = 1'b0;
    int lat = 0;
    int wcnt = 0;
    logic [31:0] rd = 32'h0;
    logic er = 1'b0;
    set_req(pb, 1'b1, we, sz, uns, addr, wd);
    #1;
    chk({tag, " ready"}, pb ? b_if.req_ready : a_if.req_ready, 32'd1);
    @(posedge clk);
    #1;
    set_req(pb, 1'b0, we, sz, uns, addr, wd);
    for (int k = 1; k <= 6; k++) begin
      if (!got) begin
        @(negedge clk);
        if (mem_write_en) wcnt++;
        if (pb ? a_if.resp_valid : b_if.resp_valid) other = 1'b1;
        if (pb ? b_if.resp_valid : a_if.resp_valid) begin
          got = 1'b1;
          lat = k;
          rd  = pb ? b_if.resp_rdata : a_if.resp_rdata;
          er  = pb ? b_if.resp_err : a_if.resp_err;
        end
      end
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " rdata"}, rd, exp_rd);
    chk({tag, " err"}, {31'd0, er}, {31'd0, exp_err});
    chk({tag, " writes"}, 32'(wcnt), 32'(exp_wr));
    chk({tag, " other port resp"}, {31'd0, other}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("reset we", {31'd0, mem_write_en}, 32'd0);
    chk("reset addr", mem_address, 32'd0);
    chk("reset din", mem_data_in, 32'd0);
    chk("reset a resp", {31'd0, a_if.resp_valid}, 32'd0);
    chk("reset b resp", {31'd0, b_if.resp_valid}, 32'd0);
    chk("reset a ready", {31'd0, a_if.req_ready}, 32'd0);
    chk("reset a rdata", a_if.resp_rdata, 32'd0);
    rst = 1'b0;

    do_req("sw 080", 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h080, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1);
    do_req("lw 080", 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h080, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0);
    do_req("sw 084", 1'b1, 1'b1, SZ_WORD, 1'b0, 32'h084, 32'hAFFECCED, 32'h0, 1'b0, 2, 1);
    do_req("sb 085", 1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h085, 32'h0000005A, 32'h0, 1'b0, 3, 1);
    chk("mem 084 after sb", mem[33], 32'hAFFE5AED);
    do_req("lbu 085", 1'b0, 1'b0, SZ_BYTE, 1'b1, 32'h085, 32'h0, 32'h0000005A, 1'b0, 2, 0);
    do_req("lh 086", 1'b0, 1'b0, SZ_HALF, 1'b0, 32'h086, 32'h0, 32'hFFFFAFFE, 1'b0, 2, 0);
    do_req("lhu 086", 1'b0, 1'b0, SZ_HALF, 1'b1, 32'h086, 32'h0, 32'h0000AFFE, 1'b0, 2, 0);
    do_req("lb 084", 1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h084, 32'h0, 32'hFFFFFFED, 1'b0, 2, 0);
    do_req("sh 086", 1'b0, 1'b1, SZ_HALF, 1'b0, 32'h086, 32'h00001234, 32'h0, 1'b0, 3, 1);
    do_req("lw 084", 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h084, 32'h0, 32'h12345AED, 1'b0, 2, 0);

    do_req("err lw 082", 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h082, 32'h0, 32'h0, 1'b1, 1, 0);
    do_req("err sh 081", 1'b1, 1'b1, SZ_HALF, 1'b0, 32'h081, 32'h0000FFFF, 32'h0, 1'b1, 1, 0);
    do_req("err lw 400", 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1, 1, 0);
    do_req("err size11", 1'b1, 1'b0, 2'b11, 1'b0, 32'h080, 32'h0, 32'h0, 1'b1, 1, 0);
    chk("mem 084 after errs", mem[33], 32'h12345AED);

    // Both ports held valid: grants alternate A, B, A, B.
    set_req(1'b0, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h080, 32'h0);
    set_req(1'b1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h084, 32'h0);
    for (int r = 0; r < 4; r++) begin
      #1;
      chk($sformatf("arb%0d a ready", r), {31'd0, a_if.req_ready}, (r % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("arb%0d b ready", r), {31'd0, b_if.req_ready}, (r % 2 == 1) ? 32'd1 : 32'd0);
      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      chk($sformatf("arb%0d a resp", r), {31'd0, a_if.resp_valid}, (r % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("arb%0d b resp", r), {31'd0, b_if.resp_valid}, (r % 2 == 1) ? 32'd1 : 32'd0);
      chk($sformatf("arb%0d a rdata", r), a_if.resp_rdata, (r % 2 == 0) ? 32'hDEADBEEF : 32'h0);
      chk($sformatf("arb%0d b rdata", r), b_if.resp_rdata, (r % 2 == 1) ? 32'h12345AED : 32'h0);
      @(negedge clk);
    end
    set_req(1'b0, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    @(negedge clk);

    // Reset asserted during the WR phase of a byte store.
    set_req(1'b0, 1'b1, 1'b1, SZ_BYTE, 1'b0, 32'h085, 32'h00000077);
    #1;
    chk("rst sb ready", {31'd0, a_if.req_ready}, 32'd1);
    @(posedge clk);
    #1;
    set_req(1'b0, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("rst sb in WR", {31'd0, mem_write_en}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("rst we drop", {31'd0, mem_write_en}, 32'd0);
    chk("rst addr drop", mem_address, 32'd0);
    chk("rst a resp", {31'd0, a_if.resp_valid}, 32'd0);
    chk("rst b resp", {31'd0, b_if.resp_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst store lost", mem[33], 32'h12345AED);
    set_req(1'b0, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h084, 32'h0);
    set_req(1'b1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h080, 32'h0);
    #1;
    chk("post-rst a ready", {31'd0, a_if.req_ready}, 32'd1);
    chk("post-rst b ready", {31'd0, b_if.req_ready}, 32'd0);
    @(posedge clk);
    #1;
    set_req(1'b0, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("post-rst a resp", {31'd0, a_if.resp_valid}, 32'd1);
    chk("post-rst a rdata", a_if.resp_rdata, 32'h12345AED);
    chk("post-rst b resp", {31'd0, b_if.resp_valid}, 32'd0);
    @(negedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
